// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one 8-bit ALU among NUM_REQ requesters.
// Optional ALU_RR_SCHED_STATS_EN adds a saturating response counter (op_count_o).
module alu_rr_sched #(
   parameter  int NUM_REQ = 4,
   localparam int IDW     = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NUM_REQ-1:0]   req_valid_i,
   input  logic [NUM_REQ*8-1:0] req_a_i,
   input  logic [NUM_REQ*8-1:0] req_b_i,
   input  logic [NUM_REQ*3-1:0] req_op_i,
   input  logic                 rsp_ready_i,
   output logic [NUM_REQ-1:0]   req_ready_o,
   output logic                 rsp_valid_o,
   output logic [IDW-1:0]       rsp_id_o,
   output logic [7:0]           rsp_data_o
`ifdef ALU_RR_SCHED_STATS_EN
   ,
   output logic [15:0]          op_count_o
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_e;

   state_e         state_q, state_d;
   logic [IDW-1:0] last_q, last_d;
   logic [IDW-1:0] cand, gnt_idx;
   logic           found;
   logic [7:0]     a_q, a_d, b_q, b_d;
   logic [2:0]     op_q, op_d;
   logic [7:0]     a_sel, b_sel;
   logic [2:0]     op_sel;
   logic [7:0]     alu_res;
   logic           rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0] rsp_id_q, rsp_id_d;
   logic [7:0]     rsp_data_q, rsp_data_d;

   // Search starts one past the last grant and wraps.
   always_comb begin
      cand    = '0;
      gnt_idx = '0;
      found   = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = IDW'((int'(last_q) + i) % NUM_REQ);
         if (!found && req_valid_i[cand]) begin
            found   = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   always_comb begin
      a_sel  = '0;
      b_sel  = '0;
      op_sel = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (gnt_idx == IDW'(k)) begin
            a_sel  = req_a_i[8*k +: 8];
            b_sel  = req_b_i[8*k +: 8];
            op_sel = req_op_i[3*k +: 3];
         end
      end
   end

   always_comb begin
      req_ready_o = '0;
      if (state_q == IDLE && found) begin
         req_ready_o[gnt_idx] = 1'b1;
      end
   end

   always_comb begin
      alu_res = '0;
      unique case (op_q)
         3'b000: alu_res = a_q + b_q;
         3'b001: alu_res = a_q - b_q;
         3'b010: alu_res = {a_q[4:0], b_q[2:0]};
         3'b011: alu_res = {b_q[2:0], a_q[7:3]};
         3'b100: alu_res = a_q & b_q;
         3'b101: alu_res = a_q | b_q;
         3'b110: alu_res = a_q ^ b_q;
         3'b111: alu_res = (a_q == b_q) ? 8'hFF : 8'h00;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               a_d     = a_sel;
               b_d     = b_sel;
               op_d    = op_sel;
               last_d  = gnt_idx;
               state_d = EXEC;
            end
         end
         EXEC: begin
            rsp_data_d  = alu_res;
            rsp_id_d    = last_q;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end
         RESP: begin
            if (rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         last_q      <= IDW'(NUM_REQ - 1);
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_id_o    = rsp_id_q;
   assign rsp_data_o  = rsp_data_q;

`ifdef ALU_RR_SCHED_STATS_EN
   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (rsp_valid_q && rsp_ready_i && cnt_q != 16'hFFFF) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign op_count_o = cnt_q;
`endif

endmodule

// File: tb/tb_alu_rr_sched.sv
// Directed bench for alu_rr_sched: grants, ALU ops, fairness,
// backpressure and mid-op reset, with immediate-assertion checks.
module tb_alu_rr_sched;

   logic        clk;
   logic        reset_n;
   logic [3:0]  req_valid_i;
   logic [31:0] req_a_i;
   logic [31:0] req_b_i;
   logic [11:0] req_op_i;
   logic        rsp_ready_i;
   logic [3:0]  req_ready_o;
   logic        rsp_valid_o;
   logic [1:0]  rsp_id_o;
   logic [7:0]  rsp_data_o;
`ifdef ALU_RR_SCHED_STATS_EN
   logic [15:0] op_count_o;
`endif

   int total = 0;
   int bad   = 0;

   alu_rr_sched #(.NUM_REQ(4)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_valid_i (req_valid_i),
      .req_a_i     (req_a_i),
      .req_b_i     (req_b_i),
      .req_op_i    (req_op_i),
      .rsp_ready_i (rsp_ready_i),
      .req_ready_o (req_ready_o),
      .rsp_valid_o (rsp_valid_o),
      .rsp_id_o    (rsp_id_o),
      .rsp_data_o  (rsp_data_o)
`ifdef ALU_RR_SCHED_STATS_EN
      ,
      .op_count_o  (op_count_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_req(input int k, input logic [7:0] a,
                          input logic [7:0] b, input logic [2:0] op);
      req_a_i[8*k +: 8]  = a;
      req_b_i[8*k +: 8]  = b;
      req_op_i[3*k +: 3] = op;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Called at a negedge in IDLE with rsp_ready_i high.
   task automatic run_op(input string tag, input int k,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic [7:0] exp);
      set_req(k, a, b, op);
      req_valid_i = 4'b0001 << k;
      #1 chk({tag, "_rdy"}, 16'(req_ready_o), 16'(4'b0001 << k));
      cyc();
      req_valid_i = 4'b0000;
      #1 chk({tag, "_exec_rdy"}, 16'(req_ready_o), 16'h0000);
      chk({tag, "_exec_vld"}, 16'(rsp_valid_o), 16'h0000);
      cyc();
      chk({tag, "_vld"}, 16'(rsp_valid_o), 16'h0001);
      chk({tag, "_id"}, 16'(rsp_id_o), 16'(k));
      chk({tag, "_data"}, 16'(rsp_data_o), 16'(exp));
      cyc();
      chk({tag, "_done"}, 16'(rsp_valid_o), 16'h0000);
   endtask

   logic [3:0] fair_gnt [4];
   logic [7:0] fair_dat [4];

   initial begin
      fair_gnt = '{4'h1, 4'h2, 4'h4, 4'h8};
      fair_dat = '{8'h00, 8'h11, 8'h22, 8'h33};
      reset_n     = 1'b0;
      req_valid_i = '0;
      req_a_i     = '0;
      req_b_i     = '0;
      req_op_i    = '0;
      rsp_ready_i = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      #1 chk("rst_vld", 16'(rsp_valid_o), 16'h0000);
      chk("rst_id", 16'(rsp_id_o), 16'h0000);
      chk("rst_data", 16'(rsp_data_o), 16'h0000);
      chk("rst_rdy", 16'(req_ready_o), 16'h0000);
`ifdef ALU_RR_SCHED_STATS_EN
      chk("rst_cnt", op_count_o, 16'h0000);
`endif

      run_op("add", 1, 8'h0F, 8'h01, 3'b000, 8'h10);
      run_op("subwrap", 2, 8'h00, 8'h01, 3'b001, 8'hFF);
      run_op("eq", 3, 8'h5A, 8'h5A, 3'b111, 8'hFF);
      run_op("neq", 0, 8'h5A, 8'h5B, 3'b111, 8'h00);
      run_op("cat", 1, 8'hB6, 8'h05, 3'b010, 8'hB5);
      run_op("rot", 2, 8'hB6, 8'h05, 3'b011, 8'hB6);
      run_op("xor", 3, 8'hF0, 8'h3C, 3'b110, 8'hCC);
`ifdef ALU_RR_SCHED_STATS_EN
      chk("cnt7", op_count_o, 16'd7);
`endif

      // Fairness: all four asserted straight out of reset.
      do_reset();
      for (int k = 0; k < 4; k++) begin
         set_req(k, 8'(8'h10 * k), 8'(k), 3'b000);
      end
      req_valid_i = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         #1 chk("fair_gnt", 16'(req_ready_o), 16'(fair_gnt[n % 4]));
         cyc();
         chk("fair_exec", 16'(req_ready_o), 16'h0000);
         cyc();
         chk("fair_id", 16'(rsp_id_o), 16'(n % 4));
         chk("fair_data", 16'(rsp_data_o), 16'(fair_dat[n % 4]));
         chk("fair_rdy0", 16'(req_ready_o), 16'h0000);
         cyc();
      end
      req_valid_i = 4'b0000;

      // Backpressure for five cycles, accept on the sixth.
      rsp_ready_i = 1'b0;
      set_req(2, 8'h3C, 8'h0F, 3'b100);
      req_valid_i = 4'b0100;
      #1 chk("bp_gnt", 16'(req_ready_o), 16'h0004);
      cyc();
      req_valid_i = 4'b0000;
      cyc();
      set_req(0, 8'h0F, 8'hF0, 3'b101);
      req_valid_i = 4'b0001;
      for (int i = 0; i < 5; i++) begin
         #1 chk("bp_vld", 16'(rsp_valid_o), 16'h0001);
         chk("bp_id", 16'(rsp_id_o), 16'h0002);
         chk("bp_data", 16'(rsp_data_o), 16'h000C);
         chk("bp_rdy", 16'(req_ready_o), 16'h0000);
         cyc();
      end
      rsp_ready_i = 1'b1;
      #1 chk("bp_last_vld", 16'(rsp_valid_o), 16'h0001);
      chk("bp_last_data", 16'(rsp_data_o), 16'h000C);
      cyc();
      #1 chk("bp_idle_vld", 16'(rsp_valid_o), 16'h0000);
      chk("bp_idle_gnt", 16'(req_ready_o), 16'h0001);
      cyc();
      req_valid_i = 4'b0000;
      cyc();
      chk("bp_or_id", 16'(rsp_id_o), 16'h0000);
      chk("bp_or_data", 16'(rsp_data_o), 16'h00FF);
      cyc();
      chk("bp_or_done", 16'(rsp_valid_o), 16'h0000);
`ifdef ALU_RR_SCHED_STATS_EN
      chk("cnt7b", op_count_o, 16'd7);
`endif

      // Reset while a result is held in RESP.
      rsp_ready_i = 1'b0;
      set_req(1, 8'h01, 8'h01, 3'b000);
      req_valid_i = 4'b0010;
      #1 chk("mr_gnt", 16'(req_ready_o), 16'h0002);
      cyc();
      req_valid_i = 4'b0000;
      cyc();
      chk("mr_vld", 16'(rsp_valid_o), 16'h0001);
      set_req(0, 8'h22, 8'h11, 3'b001);
      set_req(2, 8'h77, 8'h77, 3'b100);
      req_valid_i = 4'b0101;
      #1 chk("mr_rdy", 16'(req_ready_o), 16'h0000);
      reset_n = 1'b0;
      #1 chk("mr_async", 16'(rsp_valid_o), 16'h0000);
`ifdef ALU_RR_SCHED_STATS_EN
      chk("mr_cnt", op_count_o, 16'h0000);
`endif
      @(posedge clk);
      @(negedge clk);
      reset_n     = 1'b1;
      rsp_ready_i = 1'b1;
      #1 chk("mr_first", 16'(req_ready_o), 16'h0001);
      chk("mr_nostale", 16'(rsp_valid_o), 16'h0000);
      cyc();
      req_valid_i = 4'b0000;
      chk("mr_exec_vld", 16'(rsp_valid_o), 16'h0000);
      cyc();
      chk("mr_id", 16'(rsp_id_o), 16'h0000);
      chk("mr_data", 16'(rsp_data_o), 16'h0011);
      cyc();
      chk("mr_done", 16'(rsp_valid_o), 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_rr_sched.md
Name: alu_rr_sched

Overview:
- Round-robin scheduler that shares one 8-bit ALU datapath among NUM_REQ requesters.
- Each requester presents an operand pair and an opcode with a valid/ready handshake.
- The block grants one requester, captures its operands, executes the op, and returns the result tagged with the requester id on a single response channel with backpressure.
- It sits between several client blocks and the shared ALU function, which is implemented inside this block.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- IDW, $clog2(NUM_REQ), width of the requester id (derived; not to be overridden).

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req_valid_i  input  NUM_REQ  per-requester request valid.
- req_a_i  input  NUM_REQ*8  operand A; requester k occupies bits [8k+7:8k].
- req_b_i  input  NUM_REQ*8  operand B; same packing as req_a_i.
- req_op_i  input  NUM_REQ*3  opcode; requester k occupies bits [3k+2:3k].
- req_ready_o  output  NUM_REQ  one-hot accept strobe (combinational).
- rsp_valid_o  output  1  result valid.
- rsp_id_o  output  IDW  index of the requester that owns the result.
- rsp_data_o  output  8  ALU result.
- rsp_ready_i  input  1  consumer accepts the result.

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE; rsp_valid_o=0, rsp_id_o=0, rsp_data_o=0.
  - Round-robin pointer last_grant = NUM_REQ-1, so requester 0 has first priority.
  - Operand registers cleared.
- State machine IDLE -> EXEC -> RESP -> IDLE:
  - IDLE:
    - If any req_valid_i bit is set, grant g = first set bit searching upward from last_grant+1, wrapping modulo NUM_REQ.
    - Assert req_ready_o[g]=1 in the same cycle.
    - Capture a, b, op of g and set last_grant=g.
    - Next state EXEC.
    - If no valid bit is set, req_ready_o=0 and the block stays in IDLE.
  - EXEC: compute the ALU result from the captured operands; register rsp_data_o and rsp_id_o=g; set rsp_valid_o=1; next state RESP.
  - RESP:
    - Hold rsp_valid_o, rsp_id_o and rsp_data_o stable while rsp_ready_i=0.
    - On rsp_valid_o & rsp_ready_i, clear rsp_valid_o and go to IDLE.
- req_ready_o is 0 in EXEC and RESP. A handshake completes only when req_valid_i[k] & req_ready_o[k].
- Timing:
  - Latency: accept in cycle T -> rsp_valid_o high from cycle T+2.
  - Peak throughput: one op per 3 cycles when rsp_ready_i is held high.
- ALU functions (8-bit, all results truncated to 8 bits, carry/borrow discarded):
  - 000 add: a+b.
  - 001 sub: a-b (wraps modulo 256).
  - 010: {a[4:0], b[2:0]}.
  - 011: {b[2:0], a[7:3]}.
  - 100: a&b.
  - 101: a|b.
  - 110: a^b.
  - 111: 8'hFF if a==b, else 8'h00.
- Boundary conditions:
  - A requester dropping valid while not granted is legal and is simply skipped.
  - Inputs of non-granted requesters are ignored.
  - Pointer wrap: after granting NUM_REQ-1, the search starts at requester 0.
  - A single persistent requester is re-granted every transaction (no idle penalty).
  - reset_n asserted in EXEC or RESP drops the in-flight result silently; rsp_valid_o falls asynchronously.

Optional Feature:
- Macro ALU_RR_SCHED_STATS_EN.
- When defined:
  - Adds output port op_count_o [15:0], a count of completed response handshakes.
  - The count saturates at 16'hFFFF and resets to 0.
- When undefined: the port and counter are absent and all other behaviour is identical.

Test Plan:
- Single requester: req 1 valid, a=8'h0F, b=8'h01, op=000, rsp_ready_i=1 -> req_ready_o=4'b0010 in cycle T; rsp_valid_o at T+2 with rsp_id_o=1, rsp_data_o=8'h10.
- Wrap and equality cases:
  - a=8'h00, b=8'h01, op=001 -> 8'hFF.
  - a=8'h5A, b=8'h5A, op=111 -> 8'hFF.
  - b=8'h5B with a=8'h5A, op=111 -> 8'h00.
- Fairness: all 4 valid continuously after reset -> grant order 0,1,2,3,0, one grant per 3 cycles.
- Backpressure: rsp_ready_i=0 for 5 cycles in RESP -> rsp_id_o and rsp_data_o stable, req_ready_o=0 throughout; acceptance on cycle 6 -> IDLE next cycle.
- Shift/concat ops: a=8'hB6, b=8'h05:
  - op=010 -> 8'hB5.
  - op=011 -> 8'hB6.
- Reset mid-op: reset_n low during RESP -> rsp_valid_o=0 immediately; after release, requester 0 is granted first and no stale response appears. With ALU_RR_SCHED_STATS_EN, op_count_o returns to 0.
